cache_traffic_gen: RTL and testbench

Parametrised, synthesizable traffic generator and checker that masters the CPU-side port of generic_cache.
- Issues sequences of reads and writes with a configurable base, stride, count and mode.
- Writes a deterministic address-derived data pattern, and checks read data against the same pattern.
- Collects error counts and latency statistics, replacing hand-written bench loops in cache and system-level regressions.

---
 rtl/cache_traffic_gen_pkg.sv | 32 +++
 rtl/cache_traffic_gen_if.sv | 26 ++
 rtl/cache_traffic_gen_stats.sv | 64 ++++++
 rtl/cache_traffic_gen.sv | 172 +++++++++++++++++
 tb/tb_cache_traffic_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_traffic_gen_pkg.sv
// Shared types and the address-derived data pattern for the cache traffic
// generator.
//   tg_mode_e  : run mode (write, read/check, write-then-read, interleave)
//   tg_state_e : sequencer state
//   tg_pattern : 32-bit lane of the write data / read expectation
package cache_tg_pkg;

  typedef enum logic [1:0] {
    TG_WRITE      = 2'd0,
    TG_READ_CHECK = 2'd1,
    TG_WR_RD      = 2'd2,
    TG_INTERLEAVE = 2'd3
  } tg_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_GAP,
    ST_FIN
  } tg_state_e;

  // lane k = (addr << 2) ^ seed ^ k
  function automatic logic [31:0] tg_pattern(input logic [63:0] addr,
                                             input logic [31:0] seed,
                                             input int unsigned lane);
    logic [63:0] sh;
    sh = addr << 2;
    return sh[31:0] ^ seed ^ lane;
  endfunction

endpackage

// File: rtl/cache_traffic_gen_if.sv
// CPU-side cache port driven by the traffic generator.
//   master : generator side (drives address, strobes, write data)
//   slave  : cache side (drives read data, read valid, waitrequest)
interface cache_traffic_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic                    cpu_rd;
  logic                    cpu_wr;
  logic [DATA_WIDTH/8-1:0] cpu_wr_be;
  logic [DATA_WIDTH-1:0]   cpu_wr_data;
  logic [DATA_WIDTH-1:0]   cpu_rd_data;
  logic                    cpu_rd_valid;
  logic                    cpu_waitrequest;

  modport master (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wr_be, cpu_wr_data,
    input  cpu_rd_data, cpu_rd_valid, cpu_waitrequest
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wr_be, cpu_wr_data,
    output cpu_rd_data, cpu_rd_valid, cpu_waitrequest
  );
endinterface

// File: rtl/cache_traffic_gen_stats.sv
// Per-op latency counter plus run statistics.
//   clock, reset_n : clock, async active-low reset
//   clear          : start of a new run, zeroes all statistics
//   in_op, accept  : request outstanding / accepted this edge
//   bad_read       : accepted read whose data mismatched
//   op_addr        : address of the current op
//   lat_cur        : posedges spent on the current op so far (incl. this one)
//   err_count, first_err_addr, lat_total, lat_max : run statistics
module cache_tg_stats #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int LAT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  in_op,
  input  logic                  accept,
  input  logic                  bad_read,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  output logic [LAT_WIDTH-1:0]  lat_cur,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [LAT_WIDTH-1:0]  lat_total,
  output logic [LAT_WIDTH-1:0]  lat_max
);

  logic [LAT_WIDTH:0] sum;
  assign sum = {1'b0, lat_total} + {1'b0, lat_cur};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_cur        <= LAT_WIDTH'(1);
      err_count      <= '0;
      first_err_addr <= '0;
      lat_total      <= '0;
      lat_max        <= '0;
    end else begin
      // Idles at 1 so the first request cycle already counts as one posedge.
      if (in_op && !accept) begin
        if (lat_cur != '1) lat_cur <= lat_cur + LAT_WIDTH'(1);
      end else begin
        lat_cur <= LAT_WIDTH'(1);
      end

      if (clear) begin
        err_count      <= '0;
        first_err_addr <= '0;
        lat_total      <= '0;
        lat_max        <= '0;
      end else begin
        if (accept) begin
          lat_total <= sum[LAT_WIDTH] ? '1 : sum[LAT_WIDTH-1:0];
          if (lat_cur > lat_max) lat_max <= lat_cur;
        end
        if (bad_read) begin
          if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
          if (err_count == '0) first_err_addr <= op_addr;
        end
      end
    end
  end

endmodule

// File: rtl/cache_traffic_gen.sv
// Traffic generator / checker mastering the CPU port of a cache.
//   clock, reset_n        : clock, async active-low reset
//   start, mode, base_addr, stride, count, seed : run setup, latched on start
//   bus (master)          : cache CPU port
//   busy, done, timeout   : run status
//   err_count, first_err_addr, lat_total, lat_max : run statistics
module cache_traffic_gen
  import cache_tg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int LAT_WIDTH  = 32,
  parameter int TIMEOUT    = 1024,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [31:0]           seed,
  cache_traffic_gen_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [LAT_WIDTH-1:0]  lat_total,
  output logic [LAT_WIDTH-1:0]  lat_max
);

  // With no configured gap, one idle cycle still separates ops so the
  // request strobes never depend combinationally on waitrequest.
  localparam int unsigned GAP_LEN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int unsigned GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int unsigned LANES   = DATA_WIDTH / 32;

  tg_state_e             state, state_nxt, resume, follow;
  tg_mode_e              mode_q;
  logic [ADDR_WIDTH-1:0] base_q, stride_q, addr_q;
  logic [CNT_WIDTH-1:0]  cnt_q, idx_q;
  logic [31:0]           seed_q;
  logic [GW-1:0]         gap_q;
  logic [DATA_WIDTH-1:0] pattern;
  logic [LAT_WIDTH-1:0]  lat_cur;
  logic                  launch, in_op, accept, last, expire, mismatch, run_end;
  logic                  unused_rd_valid;

  assign unused_rd_valid = bus.cpu_rd_valid;

  assign launch   = (state == ST_IDLE) && start;
  assign in_op    = (state == ST_WR) || (state == ST_RD);
  assign accept   = in_op && !bus.cpu_waitrequest;
  assign last     = (idx_q == cnt_q - CNT_WIDTH'(1));
  assign expire   = (TIMEOUT != 0) && in_op && bus.cpu_waitrequest &&
                    (lat_cur == LAT_WIDTH'(TIMEOUT));
  assign mismatch = (state == ST_RD) && (bus.cpu_rd_data != pattern);
  assign run_end  = accept && last && ((state == ST_RD) || (mode_q == TG_WRITE));

  always_comb begin
    pattern = '0;
    for (int unsigned k = 0; k < LANES; k++)
      pattern[k*32 +: 32] = tg_pattern(64'(addr_q), seed_q, k);
  end

  // Op that follows the one just accepted.
  always_comb begin
    follow = ST_WR;
    if (state == ST_WR)
      follow = ((mode_q == TG_INTERLEAVE) || (mode_q == TG_WR_RD && last)) ? ST_RD : ST_WR;
    else
      follow = (mode_q == TG_INTERLEAVE) ? ST_WR : ST_RD;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)
        state_nxt = (count == '0) ? ST_FIN :
                    (tg_mode_e'(mode) == TG_READ_CHECK) ? ST_RD : ST_WR;
      ST_WR, ST_RD: begin
        if (accept)      state_nxt = run_end ? ST_FIN : ST_GAP;
        else if (expire) state_nxt = ST_FIN;
      end
      ST_GAP:  if (gap_q == GW'(GAP_LEN - 1)) state_nxt = resume;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = in_op || (state == ST_GAP);
    bus.cpu_wr      = (state == ST_WR);
    bus.cpu_rd      = (state == ST_RD);
    bus.cpu_addr    = addr_q;
    bus.cpu_wr_be   = '1;
    bus.cpu_wr_data = (state == ST_WR) ? pattern : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= TG_WRITE;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seed_q   <= '0;
      gap_q    <= '0;
      resume   <= ST_WR;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done <= (state == ST_FIN);
      if (launch) begin
        mode_q   <= tg_mode_e'(mode);
        base_q   <= base_addr;
        stride_q <= stride;
        addr_q   <= base_addr;
        cnt_q    <= count;
        idx_q    <= '0;
        seed_q   <= seed;
        timeout  <= 1'b0;
      end
      if (expire) timeout <= 1'b1;
      if (state == ST_GAP) gap_q <= gap_q + GW'(1);
      else                 gap_q <= '0;
      if (accept && !run_end) begin
        resume <= follow;
        // Interleave reads back the address just written; write-then-read
        // rewinds to base for the read pass.
        if (state == ST_WR && mode_q == TG_INTERLEAVE) begin
          addr_q <= addr_q;
        end else if (state == ST_WR && mode_q == TG_WR_RD && last) begin
          addr_q <= base_q;
          idx_q  <= '0;
        end else begin
          addr_q <= addr_q + stride_q;
          idx_q  <= idx_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  cache_tg_stats #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .LAT_WIDTH  (LAT_WIDTH)
  ) u_stats (
    .clock          (clock),
    .reset_n        (reset_n),
    .clear          (launch),
    .in_op          (in_op),
    .accept         (accept),
    .bad_read       (accept && mismatch),
    .op_addr        (addr_q),
    .lat_cur        (lat_cur),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .lat_total      (lat_total),
    .lat_max        (lat_max)
  );

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed bench for cache_traffic_gen with a small memory slave that
// models waitrequest stalls and can corrupt a chosen read.
module tb_cache_traffic_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] base_addr = '0;
  logic [31:0] stride = '0;
  logic [15:0] count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, lat_total, lat_max;

  cache_traffic_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_traffic_gen #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16),
    .LAT_WIDTH  (32),
    .TIMEOUT    (64),
    .GAP_CYCLES (2)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .stride         (stride),
    .count          (count),
    .seed           (seed),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .lat_total      (lat_total),
    .lat_max        (lat_max)
  );

  always #5 clock = ~clock;

  // Memory slave: stalls each request for stall_n cycles (+2 on slow_addr).
  logic [31:0] mem [0:255];
  int unsigned stall_n = 0;
  logic [31:0] slow_addr = 32'h1000;
  logic        force_wait = 1'b0;
  int unsigned stall_cnt = 0;
  logic        flip_en = 1'b0;
  int unsigned flip_at = 0;
  int unsigned wr_acc = 0, rd_acc = 0, acc_n = 0, done_n = 0;
  int unsigned wr_hi = 0, req_n = 0, both_n = 0, cyc = 0;
  logic [31:0] tr_addr [0:255];
  logic        tr_wr   [0:255];
  int unsigned tr_cyc  [0:255];
  logic        req;
  int unsigned stall_lim;

  assign req       = bus.cpu_rd | bus.cpu_wr;
  assign stall_lim = stall_n + ((bus.cpu_addr == slow_addr) ? 2 : 0);
  assign bus.cpu_waitrequest = force_wait | (req && (stall_cnt < stall_lim));
  assign bus.cpu_rd_data = mem[bus.cpu_addr[9:2]] ^ {31'b0, flip_en && (rd_acc == flip_at)};
  assign bus.cpu_rd_valid = bus.cpu_rd & ~bus.cpu_waitrequest;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (req && bus.cpu_waitrequest) stall_cnt <= stall_cnt + 1;
    else                            stall_cnt <= 0;
    if (bus.cpu_wr) wr_hi <= wr_hi + 1;
    if (req) req_n <= req_n + 1;
    if (bus.cpu_rd && bus.cpu_wr) both_n <= both_n + 1;
    if (done) done_n <= done_n + 1;
    if (req && !bus.cpu_waitrequest) begin
      tr_addr[acc_n[7:0]] <= bus.cpu_addr;
      tr_wr[acc_n[7:0]]   <= bus.cpu_wr;
      tr_cyc[acc_n[7:0]]  <= cyc;
      acc_n <= acc_n + 1;
      if (bus.cpu_wr) begin
        mem[bus.cpu_addr[9:2]] <= bus.cpu_wr_data;
        wr_acc <= wr_acc + 1;
      end
      if (bus.cpu_rd) rd_acc <= rd_acc + 1;
    end
  end

  int unsigned total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [31:0] s,
                     input logic [15:0] n, input logic [31:0] sd);
    @(negedge clock);
    mode = m; base_addr = b; stride = s; count = n; seed = sd; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    int unsigned k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk(tag, {63'b0, done}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w0, r0, d0, p0, h0, a0;
    logic [7:0]  ix;
    logic [31:0] ea;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_timeout", {63'b0, timeout}, 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_lat_total", 64'(lat_total), 64'd0);
    chk("rst_req", {63'b0, req}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: write-then-read 32 words, 1 stall per op, 3 stalls at 0xC
    stall_n = 1; slow_addr = 32'hC;
    w0 = wr_acc; r0 = rd_acc; d0 = done_n;
    run(2'd2, 32'h0, 32'h4, 16'd32, 32'h0);
    chk("t1_busy_rise", {63'b0, busy}, 64'd1);
    wait_done("t1_done", 1000);
    @(negedge clock);
    chk("t1_done_pulse", {63'b0, done}, 64'd0);
    chk("t1_wr_ops", 64'(wr_acc - w0), 64'd32);
    chk("t1_rd_ops", 64'(rd_acc - r0), 64'd32);
    chk("t1_done_count", 64'(done_n - d0), 64'd1);
    chk("t1_busy_low", {63'b0, busy}, 64'd0);
    chk("t1_err", 64'(err_count), 64'd0);
    chk("t1_lat_total", 64'(lat_total), 64'd132);
    chk("t1_lat_max", 64'(lat_max), 64'd4);
    chk("t1_mem3", 64'(mem[3]), 64'h30);
    chk("t1_mem31", 64'(mem[31]), 64'h1F0);

    // 2: corrupt 3rd read; a start pulse mid-run must be ignored
    flip_en = 1'b1; flip_at = rd_acc + 2;
    w0 = wr_acc; r0 = rd_acc;
    run(2'd2, 32'h0, 32'h4, 16'd32, 32'h0);
    repeat (20) @(negedge clock);
    mode = 2'd1; count = 16'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("t2_done", 1000);
    @(negedge clock);
    flip_en = 1'b0;
    chk("t2_err", 64'(err_count), 64'd1);
    chk("t2_first_err", 64'(first_err_addr), 64'h8);
    chk("t2_lat_total", 64'(lat_total), 64'd132);
    chk("t2_wr_ops", 64'(wr_acc - w0), 64'd32);
    chk("t2_rd_ops", 64'(rd_acc - r0), 64'd32);

    // 3: count==0
    p0 = req_n;
    run(2'd0, 32'h0, 32'h4, 16'd0, 32'h0);
    chk("t3_done_early", {63'b0, done}, 64'd0);
    @(negedge clock);
    chk("t3_done_2cyc", {63'b0, done}, 64'd1);
    @(negedge clock);
    chk("t3_done_once", {63'b0, done}, 64'd0);
    chk("t3_no_req", 64'(req_n - p0), 64'd0);
    chk("t3_err_clr", 64'(err_count), 64'd0);
    chk("t3_first_clr", 64'(first_err_addr), 64'd0);
    chk("t3_lat_clr", 64'(lat_total), 64'd0);

    // 4: timeout with waitrequest stuck high
    force_wait = 1'b1;
    h0 = wr_hi; w0 = wr_acc;
    run(2'd0, 32'h100, 32'h4, 16'd4, 32'h0);
    wait_done("t4_done", 200);
    chk("t4_wr_cycles", 64'(wr_hi - h0), 64'd64);
    chk("t4_timeout", {63'b0, timeout}, 64'd1);
    chk("t4_lat_total", 64'(lat_total), 64'd0);
    chk("t4_no_accept", 64'(wr_acc - w0), 64'd0);
    chk("t4_wr_low", {63'b0, bus.cpu_wr}, 64'd0);

    // 5: async reset mid-write
    run(2'd0, 32'h200, 32'h4, 16'd4, 32'h0);
    chk("t5_timeout_clr", {63'b0, timeout}, 64'd0);
    repeat (5) @(negedge clock);
    chk("t5_wr_pre", {63'b0, bus.cpu_wr}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_wr_async", {63'b0, bus.cpu_wr}, 64'd0);
    chk("t5_busy_async", {63'b0, busy}, 64'd0);
    chk("t5_done_async", {63'b0, done}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1; force_wait = 1'b0;
    @(negedge clock);

    // 6: interleave across address wrap, gap of 2
    stall_n = 0; slow_addr = 32'h1000;
    a0 = acc_n;
    run(2'd3, 32'hFFFF_FFF8, 32'h4, 16'd4, 32'hA5A5_0000);
    wait_done("t6_done", 200);
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ix = 8'(a0 + 32'(i));
      ea = 32'hFFFF_FFF8 + 32'(i / 2) * 32'd4;
      chk($sformatf("t6_addr%0d", i), 64'(tr_addr[ix]), 64'(ea));
      chk($sformatf("t6_kind%0d", i), {63'b0, tr_wr[ix]}, {63'b0, (i % 2) == 0});
      if (i > 0)
        chk($sformatf("t6_spacing%0d", i), 64'(tr_cyc[ix] - tr_cyc[8'(ix - 8'd1)]), 64'd3);
    end
    chk("t6_memFE", 64'(mem[8'hFE]), 64'h5A5A_FFE0);
    chk("t6_memFF", 64'(mem[8'hFF]), 64'h5A5A_FFF0);
    chk("t6_mem00", 64'(mem[8'h00]), 64'hA5A5_0000);
    chk("t6_mem01", 64'(mem[8'h01]), 64'hA5A5_0010);
    chk("t6_err", 64'(err_count), 64'd0);
    chk("t6_lat_total", 64'(lat_total), 64'd8);
    chk("t6_lat_max", 64'(lat_max), 64'd1);
    chk("t6_timeout", {63'b0, timeout}, 64'd0);
    chk("never_both", 64'(both_n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
